// File: rtl/guitar_pkg.sv
// Shared types and constants for the five-lane note scroller.
package guitar_pkg;

    localparam int NUM_LANES = 5;
    localparam logic [15:0] SCORE_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        LANE_RED    = 3'd0,
        LANE_BLUE   = 3'd1,
        LANE_GREEN  = 3'd2,
        LANE_YELLOW = 3'd3,
        LANE_ORANGE = 3'd4
    } lane_e;

    typedef enum logic {
        IDLE    = 1'b0,
        FALLING = 1'b1
    } lane_state_e;

endpackage

// File: rtl/note_lane_scroller_if.sv
// Spawn request handshake between the note sequencer and the scroller.
interface note_lane_scroller_if;

    logic       spawn_valid;
    logic [2:0] spawn_lane;
    logic       spawn_ready;

    modport master (
        output spawn_valid,
        output spawn_lane,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        output spawn_ready
    );

endinterface

// File: rtl/note_lane.sv
// One note lane: fall FSM, y register, hit window and sprite window.
module note_lane
    import guitar_pkg::*;
#(
    parameter lane_e LANE        = LANE_RED,
    parameter int    SPRITE_W    = 64,
    parameter int    SPRITE_H    = 64,
    parameter int    SCREEN_H    = 480,
    parameter int    LANE_X_BASE = 160,
    parameter int    LANE_PITCH  = 64,
    parameter int    SPEED       = 4,
    parameter int    HIT_Y       = 400,
    parameter int    HIT_WIN     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spawn,
    input  logic       frame_tick,
    input  logic       strum_tick,
    input  logic       fret_bit,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic       active,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hit,
    output logic       miss,
    output logic       is_sprite
);

    localparam int XI = LANE_X_BASE + int'(LANE) * LANE_PITCH;
    localparam logic [10:0] X0 = 11'(XI);

    lane_state_e state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] y_ext, y_next, dx, dy;
    logic        in_win, in_x, in_y;

    assign y_ext  = {1'b0, y_q};
    assign y_next = y_ext + 11'(SPEED);
    assign in_win = (y_ext + 11'(HIT_WIN) >= 11'(HIT_Y))
                 && (y_ext <= 11'(HIT_Y + HIT_WIN));

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        hit     = 1'b0;
        miss    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (spawn) begin
                    state_d = FALLING;
                    y_d     = '0;
                end
            end
            FALLING: begin
                // Strum is judged on the pre-move y, so a hit beats the move.
                if (strum_tick && fret_bit && in_win) begin
                    hit     = 1'b1;
                    state_d = IDLE;
                end else if (frame_tick) begin
                    if (y_next >= 11'(SCREEN_H)) begin
                        miss    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        y_d = y_next[9:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign dx   = {1'b0, draw_x};
    assign dy   = {1'b0, draw_y};
    assign in_x = (dx >= X0) && (dx < X0 + 11'(SPRITE_W));
    assign in_y = (dy >= y_ext) && (dy < y_ext + 11'(SPRITE_H));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) is_sprite <= 1'b0;
        else        is_sprite <= active && in_x && in_y;
    end

    assign active = (state_q == FALLING);
    assign x_pos  = X0[9:0];
    assign y_pos  = y_q;

endmodule

// File: rtl/note_lane_scroller.sv
// Five-lane note scroller: input sync, spawn decode, scoring, fan-out.
// Optional streak multiplier enabled with NOTE_STREAK_EN.
module note_lane_scroller
    import guitar_pkg::*;
#(
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 64,
    parameter int SCREEN_H    = 480,
    parameter int LANE_X_BASE = 160,
    parameter int LANE_PITCH  = 64,
    parameter int SPEED       = 4,
    parameter int HIT_Y       = 400,
    parameter int HIT_WIN     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    note_lane_scroller_if.slave  spawn,
    input  logic                 strum,
    input  logic [4:0]           fret,
    output logic [9:0]           red_x_pos,
    output logic [9:0]           red_y_pos,
    output logic [9:0]           blue_x_pos,
    output logic [9:0]           blue_y_pos,
    output logic [9:0]           green_x_pos,
    output logic [9:0]           green_y_pos,
    output logic [9:0]           yellow_x_pos,
    output logic [9:0]           yellow_y_pos,
    output logic [9:0]           orange_x_pos,
    output logic [9:0]           orange_y_pos,
    output logic                 is_sprite_red,
    output logic                 is_sprite_blue,
    output logic                 is_sprite_green,
    output logic                 is_sprite_yellow,
    output logic                 is_sprite_orange,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [15:0]          score,
    output logic [7:0]           streak
);

    logic [2:0] frame_sr, strum_sr;
    logic       frame_tick, strum_tick, run_q, lane_ok;

    logic [NUM_LANES-1:0] active, accept, hit, miss, sprite;
    logic [9:0]           x_pos [NUM_LANES];
    logic [9:0]           y_pos [NUM_LANES];

    logic [2:0]  n_hits;
    logic [4:0]  inc;
    logic [16:0] sum;
    logic [15:0] score_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sr <= '0;
            strum_sr <= '0;
            run_q    <= 1'b0;
        end else begin
            frame_sr <= {frame_sr[1:0], frame_clk};
            strum_sr <= {strum_sr[1:0], strum};
            run_q    <= 1'b1;
        end
    end

    assign frame_tick = frame_sr[1] & ~frame_sr[2];
    assign strum_tick = strum_sr[1] & ~strum_sr[2];

    // Out-of-range lanes are always ready so bad requests drain away.
    assign lane_ok = (spawn.spawn_lane <= 3'(NUM_LANES - 1));

    always_comb begin
        spawn.spawn_ready = 1'b0;
        if (run_q)
            spawn.spawn_ready = lane_ok ? !active[spawn.spawn_lane] : 1'b1;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign accept[i] = spawn.spawn_valid && spawn.spawn_ready
                        && lane_ok && (spawn.spawn_lane == 3'(i));

        note_lane #(
            .LANE        (lane_e'(i)),
            .SPRITE_W    (SPRITE_W),
            .SPRITE_H    (SPRITE_H),
            .SCREEN_H    (SCREEN_H),
            .LANE_X_BASE (LANE_X_BASE),
            .LANE_PITCH  (LANE_PITCH),
            .SPEED       (SPEED),
            .HIT_Y       (HIT_Y),
            .HIT_WIN     (HIT_WIN)
        ) u_lane (
            .clk        (Clk),
            .rst_n      (Reset_n),
            .spawn      (accept[i]),
            .frame_tick (frame_tick),
            .strum_tick (strum_tick),
            .fret_bit   (fret[i]),
            .draw_x     (DrawX),
            .draw_y     (DrawY),
            .active     (active[i]),
            .x_pos      (x_pos[i]),
            .y_pos      (y_pos[i]),
            .hit        (hit[i]),
            .miss       (miss[i]),
            .is_sprite  (sprite[i])
        );
    end

    always_comb begin
        n_hits = '0;
        for (int i = 0; i < NUM_LANES; i++)
            n_hits = n_hits + 3'(hit[i]);
    end

`ifdef NOTE_STREAK_EN
    logic [7:0] streak_q;

    assign inc = (streak_q >= 8'd8) ? {1'b0, n_hits, 1'b0}
                                    : {2'b0, n_hits};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            streak_q <= '0;
        else if ((|miss) || (strum_tick && n_hits == 3'd0))
            streak_q <= '0;
        else if (n_hits != 3'd0 && streak_q != 8'hFF)
            streak_q <= streak_q + 8'd1;
    end

    assign streak = streak_q;
`else
    assign inc    = {2'b0, n_hits};
    assign streak = '0;
`endif

    assign sum = {1'b0, score_q} + 17'(inc);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q    <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            score_q    <= sum[16] ? SCORE_MAX : sum[15:0];
            hit_pulse  <= |hit;
            miss_pulse <= |miss;
        end
    end

    assign score = score_q;

    assign red_x_pos    = x_pos[LANE_RED];
    assign red_y_pos    = y_pos[LANE_RED];
    assign blue_x_pos   = x_pos[LANE_BLUE];
    assign blue_y_pos   = y_pos[LANE_BLUE];
    assign green_x_pos  = x_pos[LANE_GREEN];
    assign green_y_pos  = y_pos[LANE_GREEN];
    assign yellow_x_pos = x_pos[LANE_YELLOW];
    assign yellow_y_pos = y_pos[LANE_YELLOW];
    assign orange_x_pos = x_pos[LANE_ORANGE];
    assign orange_y_pos = y_pos[LANE_ORANGE];

    assign is_sprite_red    = sprite[LANE_RED];
    assign is_sprite_blue   = sprite[LANE_BLUE];
    assign is_sprite_green  = sprite[LANE_GREEN];
    assign is_sprite_yellow = sprite[LANE_YELLOW];
    assign is_sprite_orange = sprite[LANE_ORANGE];

endmodule

// File: doc/note_lane_scroller.md
Name: note_lane_scroller

Overview:
- Produces the sprite positions and per-pixel sprite-hit flags consumed by the VGA colour mapper for five note lanes: red, blue, green, yellow and orange.
- Each lane holds at most one 64x64 note sprite. Notes enter from a spawn handshake and scroll down one step per video frame.
- Notes are removed on a correct strum inside the hit window, or when they leave the screen. Hits, misses and score are reported.

Parameters:
- SPRITE_W, 64, sprite width in pixels
- SPRITE_H, 64, sprite height in pixels
- SCREEN_H, 480, visible lines; a note whose y reaches this value is a miss
- LANE_X_BASE, 160, x position of lane 0 (red)
- LANE_PITCH, 64, x spacing between lanes
- SPEED, 4, pixels moved per frame tick
- HIT_Y, 400, ideal note y at strum time
- HIT_WIN, 16, allowed |y - HIT_Y| for a hit

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  reset, asynchronous, active-low
- frame_clk  in  1  VGA vsync-rate strobe, asynchronous to logic
- DrawX, DrawY  in  10 each  current pixel coordinates
- spawn_valid  in  1  spawn request
- spawn_lane  in  3  target lane, 0..4
- spawn_ready  out  1  spawn accepted this cycle when high together with spawn_valid
- strum  in  1  strum button, asynchronous level
- fret  in  5  fret buttons, bit i = lane i
- red_x_pos, red_y_pos, blue_x_pos, blue_y_pos, green_x_pos, green_y_pos, yellow_x_pos, yellow_y_pos, orange_x_pos, orange_y_pos  out  10 each  sprite top-left
- is_sprite_red, is_sprite_blue, is_sprite_green, is_sprite_yellow, is_sprite_orange  out  1 each  pixel-in-sprite flags
- hit_pulse  out  1  one-cycle pulse on any hit
- miss_pulse  out  1  one-cycle pulse on any miss
- score  out  16  hit count, saturating
- streak  out  8  consecutive-hit count (see Optional Feature)

Behaviour:
- Clocking and reset:
  - Single clock domain Clk. Reset_n is asynchronous active-low.
  - On reset: all lanes inactive, all y = 0, score = 0, streak = 0, all pulses and is_sprite flags 0, spawn_ready = 0.
- Input synchronisation:
  - frame_clk and strum each pass through a 2-flop synchroniser plus a rising-edge detect.
  - This gives one-cycle frame_tick and strum_tick signals, 3 cycles after the input edge.
- X positions:
  - x_pos for lane i = LANE_X_BASE + i*LANE_PITCH, constant. Defaults: 160, 224, 288, 352, 416.
- Y positions:
  - y_pos is a register. It changes only on frame_tick, so it is stable during the visible area.
- Spawn handshake:
  - spawn_ready = !active[spawn_lane], using registered state, when spawn_lane <= 4.
  - spawn_ready = 1 when spawn_lane > 4; the request is consumed and dropped.
  - Accept sets active = 1 and y = 0 on the next edge.
- Per-lane state machine (sub-module), states IDLE and FALLING:
  - IDLE -> FALLING on spawn accept.
  - FALLING on frame_tick: if y + SPEED >= SCREEN_H, go to IDLE and pulse miss_pulse; else y += SPEED. Use an 11-bit sum so nothing wraps.
  - FALLING on strum_tick: if fret[i] = 1 and |y - HIT_Y| <= HIT_WIN, go to IDLE and count a hit.
- Simultaneous events:
  - strum_tick and frame_tick in the same cycle: the hit is evaluated on the pre-move y. A hit lane does not move and cannot also miss.
  - A lane that goes IDLE in cycle N presents spawn_ready = 1 from cycle N+1, not earlier.
- Scoring:
  - Each strum_tick adds the number of lanes hit that cycle (0..5) to score, saturating at 16'hFFFF.
  - hit_pulse = 1 if at least one lane hit.
  - miss_pulse is the OR across lanes.
  - A strum_tick with no lane hit is a wrong strum: no score change, no pulse.
- Sprite flags:
  - is_sprite_X is registered with 1-cycle latency, so it aligns with the synchronous frame ROM read in the colour mapper.
  - is_sprite_X = active & (x <= DrawX < x+SPRITE_W) & (y <= DrawY < y+SPRITE_H), computed on the previous cycle's DrawX/DrawY.
  - Comparisons use 11-bit arithmetic.
- Reset mid-frame: all lanes clear immediately and outputs go to their reset values asynchronously.

Optional Feature:
- Macro: NOTE_STREAK_EN.
- With the macro defined:
  - streak increments, saturating at 255, on each strum_tick with at least one hit.
  - streak clears on any miss_pulse or any wrong strum.
  - While streak >= 8, each hit adds 2 to score instead of 1, still saturating.
  - If a miss and a hit occur in the same cycle, the clear wins and streak = 0.
- Without the macro: streak is tied to 0 and score increments by 1 per hit.

Decomposition:
- Package guitar_pkg:
  - lane_e enum: LANE_RED=0, LANE_BLUE=1, LANE_GREEN=2, LANE_YELLOW=3, LANE_ORANGE=4.
  - NUM_LANES = 5.
  - lane_state_e enum: IDLE, FALLING.
  - SCORE_MAX constant.
- Sub-module note_lane:
  - Holds one lane's FSM, y register, hit-window compare and sprite-window compare.
  - Instantiated 5x, indexed by lane_e.
- Top level holds the synchronisers, spawn decode, score/streak accumulation and output fan-out.

Test Plan:
- Reset, then spawn_lane=2 with spawn_valid -> spawn_ready=1, green active with green_y_pos=0, green_x_pos=288. A second spawn to lane 2 -> spawn_ready=0.
- Green active; 100 frame_clk edges -> green_y_pos=400. With SPEED=4 the next ticks reach 476; the following tick gives a miss_pulse of exactly 1 cycle and the lane goes IDLE.
- Green at y=392, fret=5'b00100, strum edge -> hit_pulse, score 0->1, lane IDLE. Same strum with green at y=380 -> no hit, score unchanged.
- Red and orange both at y=400, fret=5'b10001, strum and frame edges aligned to the same cycle -> score += 2, both lanes IDLE, neither moved, no miss_pulse.
- Red at y=100; drive DrawX=160/DrawY=100 and DrawX=224/DrawY=100 -> is_sprite_red goes 1 then 0, each one cycle after the input. Lane inactive -> flag stays 0.
- NOTE_STREAK_EN defined: 8 consecutive hits -> streak=8, score=8; 9th hit -> score=10. Then a miss -> streak=0.
